// File: rtl/ula_issue.sv
// ULA issue stage: resolves operands with EX/MEM and MEM/WB forwarding, stalls on
// load-use hazards and holds one instruction in a ready/valid output register.
package ula_pkg;
    localparam int BUS_W = 32;
    typedef logic [BUS_W-1:0] bus_type;
    typedef enum logic [2:0] {
        ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_XOR, ULA_SLT, ULA_SLL, ULA_SRL
    } ula_oper_type;
endpackage

// Per-source operand resolution; EX/MEM wins over MEM/WB, loads are never forwarded from EX/MEM.
module ula_fwd import ula_pkg::*; #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] spec,
    input  bus_type               rf_data,
    input  logic                  exm_wr_en,
    input  logic                  exm_is_load,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  bus_type               exm_result,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  bus_type               wb_data,
    output bus_type               opnd
);
    always_comb begin
        opnd = rf_data;
        if (spec == '0)
            opnd = '0;
        else if (exm_wr_en && !exm_is_load && exm_rd == spec)
            opnd = exm_result;
        else if (wb_wr_en && wb_rd == spec)
            opnd = wb_data;
    end
endmodule

module ula_issue import ula_pkg::*; #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  ula_oper_type           in_op,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    input  logic                   in_wr_en,
    input  logic [REG_ADDR_W-1:0]  in_rs,
    input  logic [REG_ADDR_W-1:0]  in_rt,
    input  bus_type                in_rs_data,
    input  bus_type                in_rt_data,
    input  bus_type                in_imm,
    input  logic                   in_use_imm,
    input  logic                   exm_wr_en,
    input  logic                   exm_is_load,
    input  logic [REG_ADDR_W-1:0]  exm_rd,
    input  bus_type                exm_result,
    input  logic                   wb_wr_en,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  bus_type                wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output bus_type                out_a,
    output bus_type                out_b,
    output ula_oper_type           out_sel,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic                   out_wr_en,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int NUM_SRC = 2;

    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_spec;
    logic [NUM_SRC-1:0][BUS_W-1:0]      src_rf;
    logic [NUM_SRC-1:0][BUS_W-1:0]      src_opnd;
    logic                               hazard;
    logic                               xfer;

    assign src_spec = {in_rt, in_rs};
    assign src_rf   = {in_rt_data, in_rs_data};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        ula_fwd #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
            .spec        (src_spec[s]),
            .rf_data     (src_rf[s]),
            .exm_wr_en   (exm_wr_en),
            .exm_is_load (exm_is_load),
            .exm_rd      (exm_rd),
            .exm_result  (exm_result),
            .wb_wr_en    (wb_wr_en),
            .wb_rd       (wb_rd),
            .wb_data     (wb_data),
            .opnd        (src_opnd[s])
        );
    end

    // rt only matters for the hazard when it actually feeds operand B
    assign hazard = in_valid && exm_is_load && exm_wr_en && (exm_rd != '0) &&
                    ((exm_rd == in_rs) || (!in_use_imm && exm_rd == in_rt));

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign xfer     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sel   <= ULA_ADD;
            out_rd    <= '0;
            out_wr_en <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (xfer)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (xfer) begin
                out_a     <= src_opnd[0];
                out_b     <= in_use_imm ? in_imm : bus_type'(src_opnd[1]);
                out_sel   <= in_op;
                out_rd    <= in_rd;
                out_wr_en <= in_wr_en && (in_rd != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
endmodule

// File: tb/tb_ula_issue.sv
// Self-checking bench for ula_issue: vector table plus scoreboard, with
// hand-written load-use, backpressure, flush and async-reset sequences.
module tb_ula_issue;
    import ula_pkg::*;

    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] rs, rt, rd;
        logic          wr_en;
        ula_oper_type  op;
        bus_type       rs_data, rt_data, imm;
        logic          use_imm;
        logic          exm_wr_en, exm_is_load;
        logic [AW-1:0] exm_rd;
        bus_type       exm_result;
        logic          wb_wr_en;
        logic [AW-1:0] wb_rd;
        bus_type       wb_data;
        bus_type       exp_a, exp_b;
        logic          exp_wr_en;
    } vec_t;

    typedef struct {
        bus_type       a, b;
        ula_oper_type  op;
        logic [AW-1:0] rd;
        logic          wr_en;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid, in_ready, in_wr_en, in_use_imm, flush, out_ready;
    ula_oper_type in_op, out_sel;
    logic [AW-1:0] in_rd, in_rs, in_rt, exm_rd, wb_rd, out_rd;
    bus_type in_rs_data, in_rt_data, in_imm, exm_result, wb_data, out_a, out_b;
    logic exm_wr_en, exm_is_load, wb_wr_en, out_valid, out_wr_en;
    logic [15:0] stall_cnt;

    int n_pass = 0, n_total = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    ula_issue #(.REG_ADDR_W(AW), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_rs(in_rs), .in_rt(in_rt),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .exm_wr_en(exm_wr_en), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_result(exm_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sel(out_sel), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [AW-1:0] rs, rt, rd, input logic wr_en, input ula_oper_type op,
        input bus_type rs_data, rt_data, imm, input logic use_imm,
        input logic xw, xl, input logic [AW-1:0] xrd, input bus_type xres,
        input logic ww, input logic [AW-1:0] wrd, input bus_type wd,
        input bus_type ea, eb, input logic ew);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.wr_en = wr_en; v.op = op;
        v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm; v.use_imm = use_imm;
        v.exm_wr_en = xw; v.exm_is_load = xl; v.exm_rd = xrd; v.exm_result = xres;
        v.wb_wr_en = ww; v.wb_rd = wrd; v.wb_data = wd;
        v.exp_a = ea; v.exp_b = eb; v.exp_wr_en = ew;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_valid = 1'b1; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_wr_en = v.wr_en;
        in_op = v.op; in_rs_data = v.rs_data; in_rt_data = v.rt_data; in_imm = v.imm;
        in_use_imm = v.use_imm; exm_wr_en = v.exm_wr_en; exm_is_load = v.exm_is_load;
        exm_rd = v.exm_rd; exm_result = v.exm_result; wb_wr_en = v.wb_wr_en;
        wb_rd = v.wb_rd; wb_data = v.wb_data;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wr_en = 1'b0;
        in_op = ULA_ADD; in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_use_imm = 1'b0;
        exm_wr_en = 1'b0; exm_is_load = 1'b0; exm_rd = '0; exm_result = '0;
        wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.a = v.exp_a; e.b = v.exp_b; e.op = v.op; e.rd = v.rd; e.wr_en = v.exp_wr_en;
        sb.push_back(e);
    endtask

    // Inputs change at posedge+1, so the negedge sees settled, edge-stable values
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_a", out_a, e.a);
                chk("out_b", out_b, e.b);
                chk("out_sel", 32'(out_sel), 32'(e.op));
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_wr_en", 32'(out_wr_en), 32'(e.wr_en));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lu, bp0, bp1, fa, fb, rc;
        idle(); flush = 1'b0; out_ready = 1'b1;

        vecs[0] = mk(3, 4, 1, 1, ULA_ADD, 'h33, 'h44, 0, 0, 1, 0, 3, 'h11, 1, 3, 'h22, 'h11, 'h44, 1);
        vecs[1] = mk(0, 0, 0, 1, ULA_OR, 'h99, 'h77, 0, 0, 1, 0, 0, 'h55, 1, 0, 'h66, 0, 0, 0);
        vecs[2] = mk(7, 7, 2, 1, ULA_AND, 1, 2, 0, 0, 1, 0, 8, 5, 1, 7, 'hAB, 'hAB, 'hAB, 1);
        vecs[3] = mk(2, 3, 9, 1, ULA_XOR, 5, 6, 'h1234, 1, 1, 0, 3, 'hEE, 0, 0, 0, 5, 'h1234, 1);
        vecs[4] = mk(10, 11, 12, 0, ULA_SLT, 'h100, 'h200, 0, 0, 0, 0, 10, 'hDEAD, 0, 11, 'hBEEF, 'h100, 'h200, 0);
        vecs[5] = mk(4, 6, 31, 1, ULA_SLL, 1, 2, 0, 0, 1, 0, 6, 'h600, 1, 4, 'h400, 'h400, 'h600, 1);
        vecs[6] = mk(14, 15, 3, 1, ULA_SRL, 'h14, 'h15, 0, 0, 1, 1, 13, 9, 1, 13, 'h77, 'h14, 'h15, 1);
        vecs[7] = mk(5, 1, 8, 1, ULA_SUB, 'h5, 1, 0, 0, 0, 1, 5, 9, 1, 5, 'h50, 'h50, 1, 1);

        // reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_sel", 32'(out_sel), 32'(ULA_ADD));
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;

        // back-to-back vectors, consumer always ready
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
            if (in_ready) push(vecs[i]);
        end
        @(posedge clk); #1; idle();
        repeat (2) @(posedge clk);

        // load-use stall on rt for two cycles, then accepted once B is the immediate
        lu = mk(1, 5, 4, 1, ULA_ADD, 'h10, 'h20, 'h30, 0, 1, 1, 5, 'h99, 0, 0, 0, 'h10, 'h30, 1);
        #1; apply(lu);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lu_in_ready", 32'(in_ready), 0);
            chk("lu_no_capture", 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        chk("lu_stall_cnt", 32'(stall_cnt), 2);
        lu.use_imm = 1'b1; apply(lu);
        @(negedge clk);
        chk("lu_imm_in_ready", 32'(in_ready), 1);
        if (in_ready) push(lu);
        @(posedge clk); #1; idle();
        repeat (2) @(posedge clk);

        // backpressure: SUB held for three cycles, then drain and fill on one edge
        bp0 = mk(1, 2, 6, 1, ULA_SUB, 'hA, 'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hA, 'hB, 1);
        bp1 = mk(1, 2, 7, 1, ULA_AND, 'hC, 'hD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hC, 'hD, 1);
        #1; out_ready = 1'b0; apply(bp0);
        @(negedge clk);
        chk("bp_first_in_ready", 32'(in_ready), 1);
        if (in_ready) push(bp0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1; apply(bp1);
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_hold_a", out_a, 'hA);
            chk("bp_hold_sel", 32'(out_sel), 32'(ULA_SUB));
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 1);
        if (in_ready) push(bp1);
        @(posedge clk); #1; idle();
        @(negedge clk);
        chk("bp_fill_valid", 32'(out_valid), 1);
        repeat (2) @(posedge clk);

        // flush: held instruction drains, incoming one is not captured
        fa = mk(9, 10, 11, 1, ULA_OR, 'h91, 'h92, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h91, 'h92, 1);
        fb = mk(9, 10, 12, 1, ULA_XOR, 'hF1, 'hF2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hF1, 'hF2, 1);
        #1; apply(fa);
        @(negedge clk); if (in_ready) push(fa);
        @(posedge clk); #1; apply(fb); flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1; flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 0);

        // async reset between edges with a valid instruction held
        rc = mk(1, 2, 3, 1, ULA_SLT, 'h71, 'h72, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h71, 'h72, 1);
        @(posedge clk); #1; out_ready = 1'b0; apply(rc);
        @(negedge clk); if (in_ready) push(rc);
        @(posedge clk); #1; idle();
        chk("ar_pre_valid", 32'(out_valid), 1);
        #2; rst_n = 1'b0; #1;
        sb.delete();
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_out_a", out_a, 0);
        chk("ar_out_b", out_b, 0);
        chk("ar_out_sel", 32'(out_sel), 32'(ULA_ADD));
        chk("ar_out_rd", 32'(out_rd), 0);
        chk("ar_out_wr_en", 32'(out_wr_en), 0);
        chk("ar_stall_cnt", 32'(stall_cnt), 0);
        chk("ar_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;

        // first capture after reset release
        @(posedge clk); #1; apply(vecs[0]);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        if (in_ready) push(vecs[0]);
        @(posedge clk); #1; idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ula_issue.md
ULA_ISSUE -- requirements
Module: ula_issue

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-specifier width; register 0 is hardwired zero.
REQ-002 Parameter: STALL_CNT_W, default 16, width of the stall performance counter.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: in_valid in 1, decoded instruction present; in_ready out 1, stage accepts instruction this cycle.
REQ-006 Ports: in_op in ula_oper_type, ALU operation; in_rd in REG_ADDR_W, destination; in_wr_en in 1, writes rd.
REQ-007 Ports: in_rs, in_rt in REG_ADDR_W, source specifiers; in_rs_data, in_rt_data in bus_type, register-file read data.
REQ-008 Ports: in_imm in bus_type, extended immediate; in_use_imm in 1, operand B is in_imm instead of rt.
REQ-009 Ports: exm_wr_en in 1, exm_is_load in 1, exm_rd in REG_ADDR_W, exm_result in bus_type: EX/MEM producer.
REQ-010 Ports: wb_wr_en in 1, wb_rd in REG_ADDR_W, wb_data in bus_type: MEM/WB producer.
REQ-011 Port: flush in 1, discard held and incoming instruction.
REQ-012 Ports: out_valid out 1; out_ready in 1, ALU consumer accepts.
REQ-013 Ports: out_a, out_b out bus_type, ALU operands; out_sel out ula_oper_type; out_rd out REG_ADDR_W; out_wr_en out 1.
REQ-014 Port: stall_cnt out STALL_CNT_W, count of hazard-stall cycles.

Function
REQ-015 Stage SHALL hold one instruction in an output register; out_* fields driven only from that register.
REQ-016 Operand resolution (combinational, on the incoming instruction) SHALL pick per source: 0 if specifier is 0; else exm_result if exm_wr_en and exm_rd matches and not exm_is_load; else wb_data if wb_wr_en and wb_rd matches; else register-file data.
REQ-017 EX/MEM forwarding SHALL take priority over MEM/WB when both match.
REQ-018 Operand B SHALL be in_imm when in_use_imm=1; rt matching is then ignored for forwarding and hazard.
REQ-019 Load-use hazard SHALL be asserted when in_valid, exm_is_load, exm_wr_en, exm_rd!=0 and exm_rd equals in_rs, or equals in_rt with in_use_imm=0.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !hazard; hazard SHALL NOT depend on out_ready.
REQ-021 Transfer in SHALL occur when in_valid && in_ready; operands, op, rd, wr_en captured; out_valid=1 next cycle; zero latency beyond one register stage.
REQ-022 If out_valid && out_ready and no transfer in, out_valid SHALL clear next cycle; simultaneous drain and fill SHALL keep out_valid=1 with new contents.
REQ-023 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-024 flush=1 SHALL clear out_valid next cycle and block capture that cycle, overriding REQ-021/022; in_ready value is unaffected.
REQ-025 stall_cnt SHALL increment by 1 each cycle in_valid && hazard && !flush; it SHALL saturate at all-ones.
REQ-026 out_wr_en SHALL be forced 0 when captured in_rd is 0.

Reset
REQ-027 On rst_n=0, asynchronously: out_valid=0, out_a=0, out_b=0, out_sel=ULA_ADD, out_rd=0, out_wr_en=0, stall_cnt=0.
REQ-028 Reset asserted mid-transfer SHALL discard the instruction; first capture allowed on first rising edge with rst_n=1.
REQ-029 in_ready SHALL be 1 during reset unless hazard is asserted (follows REQ-020 with out_valid=0).

Verification
REQ-030 Forward priority: in_rs=3, exm_rd=3 result 0x11, wb_rd=3 data 0x22, rs_data 0x33 -> out_a=0x11 one cycle later.
REQ-031 Zero register: in_rs=0, exm_rd=0 wr_en=1 result 0x55 -> out_a=0; in_rd=0 in_wr_en=1 -> out_wr_en=0.
REQ-032 Load-use: exm_is_load=1 exm_rd=5, in_rt=5 use_imm=0 for 2 cycles -> in_ready=0, no capture, stall_cnt=2; with use_imm=1 -> accepted.
REQ-033 Backpressure: capture op ULA_SUB, hold out_ready=0 for 3 cycles while new in_valid -> in_ready=0, out_* unchanged; out_ready=1 -> drain and fill same edge.
REQ-034 Flush: out_valid=1, flush=1 with in_valid=1 -> next cycle out_valid=0, instruction not captured.
REQ-035 Async reset: rst_n low between edges with out_valid=1 -> outputs per REQ-027 immediately, stall_cnt=0.
